// File: rtl/bsg_ready_and_link_wormhole_rr.sv
// Wormhole round-robin concentrator: N ready/valid input links, each buffered
// in a 2-entry FIFO, merged onto one output link without interleaving packets.
// A header flit carries the number of body flits that follow in its length field.
module bsg_ready_and_link_wormhole_rr #(
  parameter int width_p      = 64,
  parameter int num_in_p     = 2,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 7
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         mode_i,
  input  logic [num_in_p-1:0]          links_v_i,
  input  logic [num_in_p*width_p-1:0]  links_data_i,
  output logic [num_in_p-1:0]          links_ready_and_o,
  output logic                         single_v_o,
  output logic [width_p-1:0]           single_data_o,
  input  logic                         single_ready_and_i,
  output logic [num_in_p-1:0]          grant_o,
  output logic                         busy_o
);

  localparam int PW = (num_in_p > 1) ? $clog2(num_in_p) : 1;

  typedef enum logic {HDR = 1'b0, BODY = 1'b1} state_t;

  logic [num_in_p-1:0] nonempty;
  logic [num_in_p-1:0] enq;
  logic [num_in_p-1:0] deq;
  logic [width_p-1:0]  head [num_in_p];

  // Per-channel 2-entry FIFO; ready comes straight from the registered occupancy
  genvar g;
  generate
    for (g = 0; g < num_in_p; g++) begin : g_fifo
      logic [width_p-1:0] mem [2];
      logic               wr_idx;
      logic               rd_idx;
      logic [1:0]         count;

      assign nonempty[g]          = (count != 2'd0);
      assign links_ready_and_o[g] = reset_n_i & (count != 2'd2);
      assign enq[g]               = links_v_i[g] & links_ready_and_o[g];
      assign head[g]              = mem[rd_idx];

      // FIFO pointers and occupancy
      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          wr_idx <= 1'b0;
          rd_idx <= 1'b0;
          count  <= 2'd0;
        end else begin
          if (enq[g]) wr_idx <= ~wr_idx;
          if (deq[g]) rd_idx <= ~rd_idx;
          case ({enq[g], deq[g]})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
          endcase
        end
      end

      // FIFO storage; data only, no reset needed
      always_ff @(posedge clk_i) begin
        if (enq[g]) mem[wr_idx] <= links_data_i[g*width_p +: width_p];
      end
    end
  endgenerate

  state_t               state, state_nxt;
  logic [PW-1:0]        ptr, ptr_nxt;
  logic [PW-1:0]        lock, lock_nxt;
  logic [len_width_p-1:0] cnt, cnt_nxt;
  logic                 hold_v;
  logic [PW-1:0]        hold_ch;

  logic                 found;
  logic [PW-1:0]        search_ch;
  logic [PW-1:0]        sel;
  logic                 out_v;
  logic                 hs;
  logic [len_width_p-1:0] len_field;

  // Advance a channel index with wrap at num_in_p-1
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] c);
    if (int'(c) >= num_in_p - 1) return '0;
    return c + PW'(1);
  endfunction

  // First non-empty FIFO at or after ptr, wrapping around
  always_comb begin
    int idx;
    found     = 1'b0;
    search_ch = ptr;
    idx       = 0;
    for (int k = num_in_p - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= num_in_p) idx = idx - num_in_p;
      if (nonempty[idx]) begin
        found     = 1'b1;
        search_ch = PW'(idx);
      end
    end
  end

  // Output channel selection; a stalled header keeps its channel until it goes
  always_comb begin
    sel   = ptr;
    out_v = 1'b0;
    if (state == BODY) begin
      sel   = lock;
      out_v = nonempty[lock];
    end else if (hold_v) begin
      sel   = hold_ch;
      out_v = nonempty[hold_ch];
    end else if (mode_i) begin
      sel   = search_ch;
      out_v = found;
    end else begin
      sel   = ptr;
      out_v = nonempty[ptr];
    end
  end

  assign hs            = out_v & single_ready_and_i;
  assign single_v_o    = out_v;
  assign single_data_o = out_v ? head[sel] : '0;
  assign len_field     = head[sel][len_offset_p +: len_width_p];
  assign busy_o        = (state == BODY);

  // One-hot grant and dequeue strobes for the selected channel
  always_comb begin
    grant_o = '0;
    deq     = '0;
    for (int i = 0; i < num_in_p; i++) begin
      grant_o[i] = out_v & (sel == PW'(i));
      deq[i]     = hs & (sel == PW'(i));
    end
  end

  // Packet FSM: header opens a packet, counter closes it on the tail handshake
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    lock_nxt  = lock;
    cnt_nxt   = cnt;
    if (hs) begin
      if (state == HDR) begin
        if (len_field == '0) begin
          ptr_nxt = wrap_inc(sel);
        end else begin
          lock_nxt  = sel;
          cnt_nxt   = len_field;
          state_nxt = BODY;
        end
      end else begin
        cnt_nxt = cnt - len_width_p'(1);
        if (cnt == len_width_p'(1)) begin
          ptr_nxt   = wrap_inc(lock);
          state_nxt = HDR;
        end
      end
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= HDR;
      ptr     <= '0;
      lock    <= '0;
      cnt     <= '0;
      hold_v  <= 1'b0;
      hold_ch <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      lock    <= lock_nxt;
      cnt     <= cnt_nxt;
      hold_v  <= out_v & ~single_ready_and_i & (state == HDR);
      hold_ch <= sel;
    end
  end

endmodule

// File: tb/tb_bsg_ready_and_link_wormhole_rr.sv
// Bench for the wormhole round-robin concentrator: directed scenarios plus a
// randomized run against a queue-based packet model.
module tb_bsg_ready_and_link_wormhole_rr;

  localparam int W  = 32;
  localparam int N  = 2;
  localparam int LW = 4;
  localparam int LO = 7;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           mode;
  logic           single_ready;
  logic [N-1:0]   links_v;
  logic [N*W-1:0] links_data;
  logic [N-1:0]   links_ready;
  logic           single_v;
  logic [W-1:0]   single_data;
  logic [N-1:0]   grant;
  logic           busy;

  int total = 0;
  int bad   = 0;

  // Source flits not yet accepted, and model FIFO contents per channel
  logic [W-1:0] src [N][$];
  logic [W-1:0] mq  [N][$];

  int  m_ptr, m_lock, m_cnt, m_hold_ch;
  bit  m_body, m_hold;

  bit           exp_v;
  int           exp_ch;
  logic [W-1:0] exp_data;
  logic [N-1:0] exp_grant;
  logic [N-1:0] exp_ready;
  bit           exp_busy;

  bsg_ready_and_link_wormhole_rr #(
    .width_p(W), .num_in_p(N), .len_width_p(LW), .len_offset_p(LO)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .mode_i(mode),
    .links_v_i(links_v),
    .links_data_i(links_data),
    .links_ready_and_o(links_ready),
    .single_v_o(single_v),
    .single_data_o(single_data),
    .single_ready_and_i(single_ready),
    .grant_o(grant),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int ch = 0; ch < N; ch++) begin
      mq[ch].delete();
      src[ch].delete();
    end
    m_ptr = 0; m_lock = 0; m_cnt = 0; m_body = 0; m_hold = 0; m_hold_ch = 0;
  endfunction

  // Expected outputs from the packet-level rules and the model FIFO contents
  function automatic void model_eval();
    exp_v  = 0;
    exp_ch = 0;
    for (int ch = 0; ch < N; ch++) exp_ready[ch] = reset_n && (mq[ch].size() < 2);
    if (reset_n) begin
      if (m_body) begin
        exp_ch = m_lock;
        exp_v  = mq[m_lock].size() > 0;
      end else if (m_hold) begin
        exp_ch = m_hold_ch;
        exp_v  = 1;
      end else if (mode) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (!exp_v && mq[c].size() > 0) begin
            exp_v  = 1;
            exp_ch = c;
          end
        end
      end else begin
        exp_ch = m_ptr;
        exp_v  = mq[m_ptr].size() > 0;
      end
    end
    exp_busy  = reset_n && m_body;
    exp_data  = exp_v ? mq[exp_ch][0] : '0;
    exp_grant = '0;
    if (exp_v) exp_grant[exp_ch] = 1'b1;
  endfunction

  task automatic add_packet(input int ch, input int len);
    for (int i = 0; i <= len; i++) begin
      logic [W-1:0] f;
      f = $urandom;
      if (i == 0) f[LO +: LW] = LW'(len);
      src[ch].push_back(f);
    end
  endtask

  task automatic drive_sources(input int pct);
    for (int ch = 0; ch < N; ch++) begin
      if (src[ch].size() > 0 && int'($urandom_range(99)) < pct) begin
        links_v[ch] = 1'b1;
        links_data[ch*W +: W] = src[ch][0];
      end else begin
        links_v[ch] = 1'b0;
        links_data[ch*W +: W] = $urandom;
      end
    end
  endtask

  // Advance one clock edge and apply the handshakes of that edge to the model
  task automatic tick(output bit hs_out);
    bit           hs, was_body;
    logic [W-1:0] f;
    int           len;
    model_eval();
    hs       = exp_v && single_ready;
    was_body = m_body;
    @(posedge clk);
    if (hs) begin
      f = mq[exp_ch].pop_front();
      if (!was_body) begin
        len = int'(f[LO +: LW]);
        if (len == 0) m_ptr = (exp_ch + 1) % N;
        else begin
          m_body = 1; m_lock = exp_ch; m_cnt = len;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_body = 0;
          m_ptr  = (m_lock + 1) % N;
        end
      end
    end
    m_hold    = exp_v && !single_ready && !was_body;
    m_hold_ch = exp_ch;
    for (int ch = 0; ch < N; ch++) begin
      if (links_v[ch] && exp_ready[ch]) begin
        mq[ch].push_back(links_data[ch*W +: W]);
        void'(src[ch].pop_front());
      end
    end
    hs_out = hs;
  endtask

  task automatic test_reset();
    bit hs;
    reset_n = 1'b0; mode = 1'b0; single_ready = 1'b0; links_v = '0; links_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (single_v !== 1'b0) begin bad++; $display("FAIL rst_v got=%b want=0", single_v); end
    total++; if (single_data !== '0) begin bad++; $display("FAIL rst_data got=%h want=0", single_data); end
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b want=00", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (links_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b want=00", links_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++; if (links_ready !== 2'b11) begin bad++; $display("FAIL rel_ready got=%b want=11", links_ready); end
    total++; if (single_v !== 1'b0) begin bad++; $display("FAIL rel_v got=%b want=0", single_v); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rel_busy got=%b want=0", busy); end
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL rel_grant got=%b want=00", grant); end
    tick(hs);
  endtask

  task automatic test_two_packets();
    bit           hs;
    logic [W-1:0] fl [2][3];
    logic [1:0]   g;
    mode = 1'b1; single_ready = 1'b1;
    add_packet(0, 2);
    add_packet(1, 2);
    for (int i = 0; i < 3; i++) begin
      fl[0][i] = src[0][i];
      fl[1][i] = src[1][i];
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive_sources(100);
      #1;
      if (c >= 1 && c <= 6) begin
        g = (c <= 3) ? 2'b01 : 2'b10;
        total++; if (single_v !== 1'b1) begin bad++; $display("FAIL two_v c=%0d got=%b want=1", c, single_v); end
        total++; if (grant !== g) begin bad++; $display("FAIL two_grant c=%0d got=%b want=%b", c, grant, g); end
        total++; if (busy !== (c == 2 || c == 3 || c == 5 || c == 6)) begin bad++; $display("FAIL two_busy c=%0d got=%b", c, busy); end
        total++; if (single_data !== fl[c/4][(c-1)%3]) begin bad++; $display("FAIL two_data c=%0d got=%h want=%h", c, single_data, fl[c/4][(c-1)%3]); end
      end else if (c == 7) begin
        total++; if (single_v !== 1'b0) begin bad++; $display("FAIL two_idle got=%b want=0", single_v); end
      end
      tick(hs);
    end
  endtask

  task automatic test_static_mode();
    bit           hs;
    logic [W-1:0] f0, f1;
    mode = 1'b0; single_ready = 1'b1;
    add_packet(1, 0);
    f1 = src[1][0];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive_sources(100);
      #1;
      total++; if (single_v !== 1'b0) begin bad++; $display("FAIL static_stall c=%0d got=%b want=0", c, single_v); end
      tick(hs);
    end
    add_packet(0, 0);
    f0 = src[0][0];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive_sources(100);
      #1;
      if (c == 1) begin
        total++; if (grant !== 2'b01 || single_data !== f0) begin bad++; $display("FAIL static_ch0 got=%b/%h want=01/%h", grant, single_data, f0); end
      end else if (c == 2) begin
        total++; if (grant !== 2'b10 || single_data !== f1) begin bad++; $display("FAIL static_ch1 got=%b/%h want=10/%h", grant, single_data, f1); end
      end else begin
        total++; if (single_v !== 1'b0) begin bad++; $display("FAIL static_idle c=%0d got=%b want=0", c, single_v); end
      end
      tick(hs);
    end
  endtask

  task automatic test_stall();
    bit           hs;
    logic [W-1:0] fl [4];
    mode = 1'b1;
    add_packet(0, 3);
    for (int i = 0; i < 4; i++) fl[i] = src[0][i];
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      single_ready = (c <= 1 || c >= 8);
      drive_sources(100);
      #1;
      if (c == 1) begin
        total++; if (single_data !== fl[0] || busy !== 1'b0) begin bad++; $display("FAIL stall_hdr got=%h/%b want=%h/0", single_data, busy, fl[0]); end
      end
      if (c >= 2 && c <= 8) begin
        total++; if (single_v !== 1'b1 || single_data !== fl[1] || busy !== 1'b1 || grant !== 2'b01) begin
          bad++; $display("FAIL stall_hold c=%0d got=%b/%h/%b/%b want=1/%h/1/01", c, single_v, single_data, busy, grant, fl[1]);
        end
      end
      if (c >= 3 && c <= 8) begin
        total++; if (links_ready[0] !== 1'b0) begin bad++; $display("FAIL stall_ready c=%0d got=%b want=0", c, links_ready[0]); end
      end
      if (c == 9) begin
        total++; if (links_ready[0] !== 1'b1 || single_data !== fl[2]) begin bad++; $display("FAIL stall_resume got=%b/%h want=1/%h", links_ready[0], single_data, fl[2]); end
      end
      if (c == 10) begin
        total++; if (single_data !== fl[3] || busy !== 1'b1) begin bad++; $display("FAIL stall_tail got=%h/%b want=%h/1", single_data, busy, fl[3]); end
      end
      if (c == 11) begin
        total++; if (single_v !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stall_end got=%b/%b want=0/0", single_v, busy); end
      end
      tick(hs);
    end
  endtask

  task automatic test_reset_mid_packet();
    bit           hs;
    logic [W-1:0] f1;
    mode = 1'b1; single_ready = 1'b1;
    add_packet(0, 3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_sources(100);
      tick(hs);
    end
    @(negedge clk);
    reset_n = 1'b0;
    links_v = '0;
    #1;
    total++; if (single_v !== 1'b0 || busy !== 1'b0 || grant !== 2'b00 || links_ready !== 2'b00) begin
      bad++; $display("FAIL midrst_out got=%b/%b/%b/%b want=0/0/00/00", single_v, busy, grant, links_ready);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    add_packet(1, 0);
    f1 = src[1][0];
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      drive_sources(100);
      #1;
      if (c == 1) begin
        total++; if (single_v !== 1'b1 || grant !== 2'b10 || single_data !== f1) begin
          bad++; $display("FAIL midrst_ch1 got=%b/%b/%h want=1/10/%h", single_v, grant, single_data, f1);
        end
      end else begin
        total++; if (single_v !== 1'b0) begin bad++; $display("FAIL midrst_stale c=%0d got=%b want=0", c, single_v); end
      end
      tick(hs);
    end
  endtask

  task automatic test_alternate();
    bit           hs;
    logic [W-1:0] a [2][8];
    logic [1:0]   g;
    mode = 1'b1; single_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      add_packet(0, 0);
      add_packet(1, 0);
    end
    for (int k = 0; k < 8; k++) begin
      a[0][k] = src[0][k];
      a[1][k] = src[1][k];
    end
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      drive_sources(100);
      #1;
      if (c >= 1 && c <= 16) begin
        g = (c % 2 == 1) ? 2'b01 : 2'b10;
        total++; if (grant !== g) begin bad++; $display("FAIL alt_grant c=%0d got=%b want=%b", c, grant, g); end
        total++; if (single_data !== a[(c+1)%2][(c-1)/2]) begin bad++; $display("FAIL alt_data c=%0d got=%h want=%h", c, single_data, a[(c+1)%2][(c-1)/2]); end
      end
      tick(hs);
    end
  endtask

  task automatic test_random();
    bit hs;
    int expected_out, seen_out, cyc;
    expected_out = 0; seen_out = 0; cyc = 0;
    for (int ch = 0; ch < N; ch++) begin
      for (int p = 0; p < 12; p++) begin
        int len;
        len = ($urandom_range(9) == 0) ? 15 : int'($urandom_range(3));
        add_packet(ch, len);
        expected_out += len + 1;
      end
    end
    while (seen_out < expected_out && cyc < 3000) begin
      @(negedge clk);
      if (cyc % 16 == 0) mode = $urandom_range(1);
      single_ready = ($urandom_range(99) < 70);
      drive_sources(70);
      #1;
      model_eval();
      total++; if (single_v !== exp_v) begin bad++; $display("FAIL rnd_v cyc=%0d got=%b want=%b", cyc, single_v, exp_v); end
      total++; if (single_data !== exp_data) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", cyc, single_data, exp_data); end
      total++; if (grant !== exp_grant) begin bad++; $display("FAIL rnd_grant cyc=%0d got=%b want=%b", cyc, grant, exp_grant); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy); end
      total++; if (links_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, links_ready, exp_ready); end
      tick(hs);
      if (hs) seen_out++;
      cyc++;
    end
    total++; if (seen_out != expected_out) begin bad++; $display("FAIL rnd_drain got=%0d want=%0d", seen_out, expected_out); end
  endtask

  initial begin
    test_reset();
    test_two_packets();
    test_static_mode();
    test_stall();
    test_reset_mid_packet();
    test_alternate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
